// File: rtl/bsmm_input_loader.sv
// Purpose : assembles a stream of operand words into NUM_VALUES-word frames and
//           launches each complete frame onto the multiplier's values bus.
// Latency : 2 edges from the last-word accept to the start-high cycle when idle
//           (edge 1 marks the frame staged, edge 2 launches it).
// Backpressure: in_ready drops while a complete frame waits for the compute
//           window to close; in_ready returns in the same cycle start is high.
//
// Ports:
//   i_clk, i_rst       rising-edge clock, synchronous active-high reset
//   i_in_valid/o_in_ready, i_in_data, i_in_last
//                      operand word stream (valid/ready handshake)
//   o_values           NUM_VALUES x WIDTH frame to the multiplier, index 0 = first word
//   o_start            one-cycle launch pulse, coincident with new o_values
//   o_busy             compute window active
//   o_frame_error      one-cycle pulse on a short or long frame
module bsmm_input_loader #(
   parameter int NUM_VALUES     = 10,
   parameter int WIDTH          = 32,
   parameter int COMPUTE_CYCLES = 40
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_in_valid,
   output logic                              o_in_ready,
   input  logic [WIDTH-1:0]                  i_in_data,
   input  logic                              i_in_last,
   output logic [NUM_VALUES-1:0][WIDTH-1:0]  o_values,
   output logic                              o_start,
   output logic                              o_busy,
   output logic                              o_frame_error
);

   localparam int IDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
   localparam int CNT_W = $clog2(COMPUTE_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);

   logic [NUM_VALUES-1:0][WIDTH-1:0] r_stage;
   logic [NUM_VALUES-1:0][WIDTH-1:0] r_values;
   logic [IDX_W-1:0]                 r_idx;
   logic                             r_staged_full;
   logic [CNT_W-1:0]                 r_busy_cnt;
   logic                             r_start;
   logic                             r_frame_error;

   logic w_accept;
   logic w_last_slot;
   logic w_launch;

   assign o_in_ready  = !i_rst && !r_staged_full;
   assign w_accept    = i_in_valid && o_in_ready;
   assign w_last_slot = (r_idx == LAST_IDX);
   // A staged frame blocks acceptance, so a launch edge never carries a new word.
   assign w_launch    = r_staged_full && (r_busy_cnt == '0);

   // Staging buffer: contents are don't-care after reset, only the index matters.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_stage[r_idx] <= i_in_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_values      <= '0;
         r_idx         <= '0;
         r_staged_full <= 1'b0;
         r_busy_cnt    <= '0;
         r_start       <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_start       <= w_launch;
         r_frame_error <= 1'b0;

         if (r_busy_cnt != '0) begin
            r_busy_cnt <= r_busy_cnt - 1'b1;
         end

         if (w_launch) begin
            r_values      <= r_stage;
            r_staged_full <= 1'b0;
            r_busy_cnt    <= CNT_W'(COMPUTE_CYCLES);
         end

         if (w_accept) begin
            if (w_last_slot) begin
               // Frame slot count reached: either a clean frame or an overrun.
               // On an overrun the word is dropped and the next word starts a frame.
               r_idx <= '0;
               if (i_in_last) begin
                  r_staged_full <= 1'b1;
               end else begin
                  r_frame_error <= 1'b1;
               end
            end else if (i_in_last) begin
               // Short frame: drop the partial words, values keeps the old frame.
               r_idx         <= '0;
               r_frame_error <= 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   assign o_values      = r_values;
   assign o_start       = r_start;
   assign o_busy        = (r_busy_cnt != '0);
   assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_bsmm_input_loader.sv
module tb_bsmm_input_loader;

   localparam int NV = 10;
   localparam int W  = 32;
   localparam int CC = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst      = 1'b1;
   logic                     in_valid = 1'b0;
   logic                     in_last  = 1'b0;
   logic [W-1:0]             in_data  = '0;
   logic                     in_ready;
   logic                     start;
   logic                     busy;
   logic                     frame_error;
   logic [NV-1:0][W-1:0]     values;

   bsmm_input_loader #(.NUM_VALUES(NV), .WIDTH(W), .COMPUTE_CYCLES(CC)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_data     (in_data),
      .i_in_last     (in_last),
      .o_values      (values),
      .o_start       (start),
      .o_busy        (busy),
      .o_frame_error (frame_error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: frames as queues, compute window as elapsed edges since launch.
   logic [W-1:0]         m_part[$];
   logic [W-1:0]         m_pend[NV];
   bit                   m_pend_vld = 0;
   logic [NV-1:0][W-1:0] m_values = '0;
   bit                   m_start = 0;
   bit                   m_ferr  = 0;
   bit                   m_acc   = 0;
   int                   m_edge  = 0;
   int                   m_last_launch = -1000;

   int start_edges[$];
   int start_count = 0;
   int ferr_count  = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %b expected %b", nm, m_edge, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %h expected %h", nm, m_edge, act, exp);
      end
   endtask

   task automatic chkv(input string nm, input logic [NV*W-1:0] act, input logic [NV*W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %h expected %h", nm, m_edge, act, exp);
      end
   endtask

   function automatic bit m_busy();
      return (m_edge - m_last_launch) < CC;
   endfunction

   task automatic model_edge();
      bit rdy;
      m_edge++;
      m_acc   = 0;
      m_start = 0;
      m_ferr  = 0;
      rdy = !rst && !m_pend_vld;
      if (rst) begin
         m_part.delete();
         m_pend_vld    = 0;
         m_values      = '0;
         m_last_launch = -1000;
      end else if (m_pend_vld && (m_edge - m_last_launch > CC)) begin
         for (int i = 0; i < NV; i++) m_values[i] = m_pend[i];
         m_pend_vld    = 0;
         m_last_launch = m_edge;
         m_start       = 1;
      end else if (in_valid && rdy) begin
         m_acc = 1;
         m_part.push_back(in_data);
         if (m_part.size() == NV) begin
            if (in_last) begin
               for (int i = 0; i < NV; i++) m_pend[i] = m_part[i];
               m_pend_vld = 1;
            end else begin
               m_ferr = 1;
            end
            m_part.delete();
         end else if (in_last) begin
            m_ferr = 1;
            m_part.delete();
         end
      end
   endtask

   task automatic check_outputs();
      chk1("in_ready", in_ready, !rst && !m_pend_vld);
      chk1("start", start, m_start);
      chk1("busy", busy, m_busy());
      chk1("frame_error", frame_error, m_ferr);
      chkv("values", values, m_values);
      if (start === 1'b1) begin
         start_count++;
         start_edges.push_back(m_edge);
      end
      if (frame_error === 1'b1) ferr_count++;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int k);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (k) tick();
   endtask

   task automatic send(input logic [W-1:0] d, input bit last);
      int g = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      do begin
         tick();
         g++;
      end while (!m_acc && g < 200);
      n_tests++;
      if (!m_acc) begin
         n_fail++;
         $display("FAIL send_timeout @edge %0d: word %h not accepted", m_edge, d);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_start(input string nm);
      int g = 0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      do begin
         tick();
         g++;
      end while (start !== 1'b1 && g < 100);
      n_tests++;
      if (start !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_start_timeout @edge %0d: start=%b required 1", nm, m_edge, start);
      end
   endtask

   typedef struct {
      bit           rst;
      bit           vld;
      bit           last;
      logic [W-1:0] dat;
      bit           e_rdy;
      bit           e_start;
      bit           e_busy;
   } vec_t;

   vec_t tv[13];
   int   w1[10] = '{1, 3, 5, 19, 24, 12, 23, 135, -23, 20};

   initial begin
      logic [NV-1:0][W-1:0] fa, fb, fc, fd;
      logic [NV-1:0][W-1:0] v_before;
      int bc, g, d;

      // ---------------- Test 1: table-driven reset + first frame ----------------
      tv[0] = '{rst: 1'b1, vld: 1'b0, last: 1'b0, dat: '0, e_rdy: 1'b0, e_start: 1'b0, e_busy: 1'b0};
      for (int i = 0; i < 10; i++)
         tv[i+1] = '{rst: 1'b0, vld: 1'b1, last: (i == 9), dat: 32'(w1[i]),
                     e_rdy: (i != 9), e_start: 1'b0, e_busy: 1'b0};
      tv[11] = '{rst: 1'b0, vld: 1'b0, last: 1'b0, dat: '0, e_rdy: 1'b1, e_start: 1'b1, e_busy: 1'b1};
      tv[12] = '{rst: 1'b0, vld: 1'b0, last: 1'b0, dat: '0, e_rdy: 1'b1, e_start: 1'b0, e_busy: 1'b1};

      for (int i = 0; i < 13; i++) begin
         rst      = tv[i].rst;
         in_valid = tv[i].vld;
         in_last  = tv[i].last;
         in_data  = tv[i].dat;
         tick();
         chk1("tv_ready", in_ready, tv[i].e_rdy);
         chk1("tv_start", start, tv[i].e_start);
         chk1("tv_busy", busy, tv[i].e_busy);
         if (i == 0) chkv("tv_reset_values", values, '0);
         if (i == 11) begin
            chkw("t1_values0", values[0], 32'd1);
            chkw("t1_values7", values[7], 32'd135);
            chkw("t1_values8", values[8], 32'hFFFFFFE9);
            chkw("t1_values9", values[9], 32'd20);
         end
      end
      bc = 2;
      g  = 0;
      while (busy === 1'b1 && g < 100) begin
         tick();
         if (busy === 1'b1) bc++;
         g++;
      end
      chkw("t1_busy_cycles", 32'(bc), 32'(CC));

      // ---------------- Test 2: back-to-back frames A, B ----------------
      idle(3);
      start_edges.delete();
      for (int i = 0; i < NV; i++) begin
         fa[i] = $urandom;
         fb[i] = $urandom;
      end
      for (int i = 0; i < NV; i++) send(fa[i], i == NV-1);
      for (int i = 0; i < NV; i++) send(fb[i], i == NV-1);
      chk1("t2_ready_low_after_B", in_ready, 1'b0);
      chk1("t2_busy_during_A", busy, 1'b1);
      chkv("t2_values_A", values, fa);
      g = 0;
      while (start_edges.size() < 2 && g < 100) begin
         tick();
         g++;
      end
      n_tests++;
      if (start_edges.size() < 2) begin
         n_fail++;
         $display("FAIL t2_second_start: starts seen %0d required 2", start_edges.size());
      end else begin
         d = start_edges[1] - start_edges[0];
         chkw("t2_start_spacing", 32'(d), 32'(CC + 1));
         chkv("t2_values_B", values, fb);
      end

      // ---------------- Test 3: short frame ----------------
      idle(45);
      start_count = 0;
      ferr_count  = 0;
      v_before    = values;
      for (int i = 0; i < 4; i++) send($urandom, i == 3);
      idle(5);
      chkw("t3_ferr_count", 32'(ferr_count), 32'd1);
      chkw("t3_start_count", 32'(start_count), 32'd0);
      chkv("t3_values_kept", values, v_before);
      for (int i = 0; i < NV; i++) fc[i] = $urandom;
      for (int i = 0; i < NV; i++) send(fc[i], i == NV-1);
      wait_start("t3");
      chkv("t3_values_clean", values, fc);

      // ---------------- Test 4: long frame and resync ----------------
      idle(45);
      start_count = 0;
      ferr_count  = 0;
      for (int i = 0; i < NV; i++) send($urandom, 1'b0);
      idle(3);
      chkw("t4_ferr_count", 32'(ferr_count), 32'd1);
      chkw("t4_start_count", 32'(start_count), 32'd0);
      for (int i = 0; i < NV; i++) fd[i] = $urandom;
      for (int i = 0; i < NV; i++) send(fd[i], i == NV-1);
      wait_start("t4");
      chkw("t4_word11_at_0", values[0], fd[0]);
      chkv("t4_values", values, fd);

      // ---------------- Test 5: random valid, reset mid-frame ----------------
      idle(45);
      start_count = 0;
      for (int i = 0; i < 6; i++) begin
         idle($urandom_range(0, 2));
         send($urandom, 1'b0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chkv("t5_values_zero", values, '0);
      chk1("t5_busy_zero", busy, 1'b0);
      for (int i = 0; i < NV; i++) fa[i] = $urandom;
      for (int i = 0; i < NV; i++) begin
         idle($urandom_range(0, 2));
         send(fa[i], i == NV-1);
      end
      wait_start("t5");
      chkv("t5_values", values, fa);
      chkw("t5_start_count", 32'(start_count), 32'd1);

      // ---------------- Random soak against the model ----------------
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = $urandom;
         in_last  = (m_part.size() == NV-1);
         if ($urandom_range(0, 19) == 0) in_last = ~in_last;
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bsmm_input_loader.md
Name: bsmm_input_loader

Overview:
- Upstream feeder for BitSerialMatrixMultiplySpecific.
- Accepts operand words one at a time over a valid/ready stream and assembles them into a NUM_VALUES-word frame in a staging buffer.
- Transfers each complete frame to the values bus and pulses start for one cycle.
- Holds values stable for the multiplier's compute window; the next frame is staged meanwhile (double buffering).

Parameters:
- NUM_VALUES, 10, words per frame; equals the width of the multiplier's values array.
- WIDTH, 32, bits per word.
- COMPUTE_CYCLES, 40, cycles values must stay stable after a start pulse; must be >= 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  loader can accept a word.
- in_data  input  WIDTH  operand word, raw two's-complement bits.
- in_last  input  1  marks the final word of a frame.
- values  output  NUM_VALUES x WIDTH  packed array to the multiplier; index 0 is the first word received.
- start  output  1  one-cycle launch pulse to the multiplier.
- busy  output  1  compute window active (busy_cnt != 0).
- frame_error  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst high at an edge):
  - values = all 0, start = 0, busy = 0, frame_error = 0.
  - idx = 0, staged_full = 0, busy_cnt = 0.
  - Staging buffer contents are don't-care.
- in_ready = !rst && !staged_full (combinational).
- Word acceptance:
  - A word is accepted at an edge where in_valid && in_ready.
  - The accepted word is written to stage[idx]; words are passed bit-exact with no sign handling (e.g. -23 travels as 0xFFFFFFE9).
- Framing, evaluated on each accepted word:
  - idx < NUM_VALUES-1 and in_last=0: idx increments.
  - idx < NUM_VALUES-1 and in_last=1 (short frame): frame_error pulses next cycle, idx returns to 0, partial frame discarded, values unchanged.
  - idx == NUM_VALUES-1 and in_last=1: staged_full set, idx returns to 0.
  - idx == NUM_VALUES-1 and in_last=0 (long frame): frame_error pulses, idx returns to 0, frame discarded. The loader then resyncs by treating the following words as a new frame.
- Launch condition: staged_full && busy_cnt == 0, sampled at an edge. At that edge:
  - values is loaded from the staging buffer (all words at once, never partially).
  - start is driven 1 for exactly the following cycle.
  - staged_full is cleared; busy_cnt is loaded with COMPUTE_CYCLES.
- values changes only at a launch edge or at reset. values and start therefore change on the same edge, so values is valid in the cycle start is high.
- busy_cnt decrements by 1 at each edge while nonzero; busy = (busy_cnt != 0).
- Timing:
  - Minimum start-to-start spacing is COMPUTE_CYCLES+1 cycles.
  - Latency from the edge accepting the last word to the start-high cycle is 2 edges when idle: the edge that sets staged_full, then the launch edge.
- Back-pressure:
  - While staged_full=1, in_ready=0 and no words are accepted.
  - Once launched, in_ready returns to 1 in the same cycle start is high.
- Simultaneity: a launch edge never coincides with a word acceptance, because in_ready=0 while staged_full=1.
- Reset mid-frame: partial frame dropped. Reset mid-compute: busy_cnt cleared and any pending staged frame dropped.
- frame_error never coincides with start caused by the same frame.

Test Plan:
- Reset, then stream 1,3,5,19,24,12,23,135,-23,20 with in_valid held high and in_last on the 10th word -> exactly one start pulse, 2 edges after the 10th accept. values[0]=1, values[7]=135, values[8]=0xFFFFFFE9, values[9]=20 in the start cycle. busy high for the next 40 cycles.
- Send frame A, then frame B immediately -> B is fully accepted during A's busy window, then in_ready=0. The second start fires exactly 41 cycles after the first. values holds A until that edge and switches to B atomically.
- Send 4 words with in_last on the 4th -> frame_error pulses once, no start, values unchanged. The next clean 10-word frame launches normally.
- Send 10 words without in_last -> frame_error pulses, no start. The 11th word lands in values[0] of the following frame.
- Toggle in_valid randomly over 2 frames, with one cycle of rst asserted after word 6 of frame 1 -> frame 1 discarded, values reads all 0, start fires only for frame 2, with correct contents.
